// File: rtl/mac_enc_pkg.sv
// Shared definitions for the MAC TX encapsulator: header field offsets, frame limits,
// FSM encoding and the byte-wide CRC-32 step.
package mac_enc_pkg;

  localparam int unsigned DST_LSB       = 64;
  localparam int unsigned SRC_LSB       = 16;
  localparam int unsigned TYPE_LSB      = 0;
  localparam int unsigned PORT_LSB      = 112;
  localparam int unsigned PORT_W        = 2;
  localparam int unsigned FCS_OK_BIT    = 115;

  localparam int unsigned HDR_BYTES     = 14;
  localparam int unsigned MIN_FRAME_LEN = 60;
  localparam int unsigned MAX_FRAME_LEN = 1514;
  localparam int unsigned FCS_BYTES     = 4;
  localparam int unsigned CNT_W         = 11;
  localparam int unsigned NUM_PORTS     = 4;

  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PAD     = 3'd3,
    ST_FCS     = 3'd4,
    ST_DROP    = 3'd5,
    ST_END     = 3'd6
  } state_e;

  // Reflected CRC-32 (poly 0x04C11DB7), one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_enc_crc.sv
// Byte-per-cycle CRC-32 accumulator; init has priority over en.
module mac_enc_crc
  import mac_enc_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      crc <= '1;
    end else if (init) begin
      crc <= '1;
    end else if (en) begin
      crc <= crc32_byte(crc, din);
    end
  end

endmodule

// File: rtl/mac_enc.sv
// MAC TX encapsulator: header + body -> one of four PHY TX FIFOs with optional padding and FCS.
// Short-frame padding is compiled in with the MAC_ENC_PAD_EN macro.
module mac_enc
  import mac_enc_pkg::*;
#(
  parameter int unsigned HEADER_DWIDTH = 128
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
  input  logic                     h_fifo_empty,
  output logic                     h_fifo_rden,
  input  logic [7:0]               b_fifo_dout,
  input  logic                     b_fifo_empty,
  input  logic                     b_fifo_del,
  output logic                     b_fifo_rden,
  output logic [7:0]               o_fifo_din,
  output logic [NUM_PORTS-1:0]     o_fifo_wren,
  output logic                     o_fifo_del,
  input  logic [NUM_PORTS-1:0]     o_fifo_afull
);

`ifdef MAC_ENC_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int unsigned HDR_W   = HDR_BYTES * 8;
  localparam int unsigned HDR_MSB = TYPE_LSB + HDR_W - 1;

  state_e               state, state_nxt;
  logic [HDR_W-1:0]     hdr_q;
  logic [PORT_W-1:0]    port_q;
  logic [PORT_W-1:0]    port_in;
  logic [CNT_W-1:0]     byte_cnt;
  logic [1:0]           fcs_idx;
  logic [3:0]           hdr_idx;
  logic [31:0]          crc;
  logic                 fcs_ok_in;
  logic                 body_last;
  logic                 h_rden_nxt;
  logic                 wr_data;
  logic                 crc_init;
  logic                 del_nxt;
  logic [7:0]           din_nxt;
  logic [NUM_PORTS-1:0] wren_nxt;
  logic                 unused_hdr_bits;

  assign unused_hdr_bits = ^{h_fifo_dout[HEADER_DWIDTH-1:FCS_OK_BIT+1], h_fifo_dout[FCS_OK_BIT-1]};
  assign fcs_ok_in = h_fifo_dout[FCS_OK_BIT];
  assign port_in   = h_fifo_dout[PORT_LSB +: PORT_W];
  assign body_last = !b_fifo_empty && b_fifo_del;
  // Header is sent DST MSB first, so byte 0 sits at the top of hdr_q.
  assign hdr_idx   = 4'(HDR_BYTES - 1) - byte_cnt[3:0];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!h_fifo_empty) begin
          if (!fcs_ok_in)                   state_nxt = ST_DROP;
          else if (!o_fifo_afull[port_in]) state_nxt = ST_HEADER;
        end
      end
      ST_HEADER:  if (byte_cnt == CNT_W'(HDR_BYTES - 1)) state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (body_last) begin
          if (PAD_EN && (byte_cnt < CNT_W'(MIN_FRAME_LEN - 1))) state_nxt = ST_PAD;
          else                                                   state_nxt = ST_FCS;
        end
      end
      ST_PAD:     if (byte_cnt == CNT_W'(MIN_FRAME_LEN - 1)) state_nxt = ST_FCS;
      ST_FCS:     if (fcs_idx == 2'(FCS_BYTES - 1)) state_nxt = ST_END;
      ST_DROP:    if (body_last) state_nxt = ST_END;
      ST_END:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_END;
    endcase
  end

  always_comb begin
    h_rden_nxt  = 1'b0;
    b_fifo_rden = 1'b0;
    wr_data     = 1'b0;
    crc_init    = 1'b0;
    del_nxt     = 1'b0;
    din_nxt     = 8'h00;
    wren_nxt    = '0;
    case (state)
      ST_IDLE: begin
        if (!h_fifo_empty && (!fcs_ok_in || !o_fifo_afull[port_in])) begin
          h_rden_nxt = 1'b1;
          crc_init   = fcs_ok_in;
        end
      end
      ST_HEADER: begin
        wr_data  = 1'b1;
        din_nxt  = hdr_q[{hdr_idx, 3'd0} +: 8];
        wren_nxt = NUM_PORTS'(1) << port_q;
      end
      ST_PAYLOAD: begin
        if (!b_fifo_empty) begin
          b_fifo_rden = 1'b1;
          wr_data     = 1'b1;
          din_nxt     = b_fifo_dout;
          wren_nxt    = NUM_PORTS'(1) << port_q;
        end
      end
      ST_PAD: begin
        wr_data  = 1'b1;
        wren_nxt = NUM_PORTS'(1) << port_q;
      end
      ST_FCS: begin
        din_nxt  = ~crc[{fcs_idx, 3'd0} +: 8];
        wren_nxt = NUM_PORTS'(1) << port_q;
        del_nxt  = (fcs_idx == 2'(FCS_BYTES - 1));
      end
      ST_DROP: b_fifo_rden = !b_fifo_empty;
      default: ;
    endcase
  end

  // Registered outputs, latched header and frame counters.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      h_fifo_rden <= 1'b0;
      o_fifo_din  <= 8'h00;
      o_fifo_wren <= '0;
      o_fifo_del  <= 1'b0;
      hdr_q       <= '0;
      port_q      <= '0;
      byte_cnt    <= '0;
      fcs_idx     <= '0;
    end else begin
      h_fifo_rden <= h_rden_nxt;
      o_fifo_din  <= din_nxt;
      o_fifo_wren <= wren_nxt;
      o_fifo_del  <= del_nxt;
      if ((state == ST_IDLE) && (state_nxt != ST_IDLE)) begin
        hdr_q  <= h_fifo_dout[HDR_MSB:TYPE_LSB];
        port_q <= port_in;
      end
      if (wr_data && (byte_cnt != '1)) byte_cnt <= byte_cnt + CNT_W'(1);
      if (state == ST_FCS) fcs_idx <= fcs_idx + 2'd1;
      if (state == ST_END) begin
        hdr_q    <= '0;
        port_q   <= '0;
        byte_cnt <= '0;
        fcs_idx  <= '0;
      end
    end
  end

  mac_enc_crc u_crc (
    .clk    (clk),
    .arst_n (arst_n),
    .init   (crc_init),
    .en     (wr_data),
    .din    (din_nxt),
    .crc    (crc)
  );

endmodule

// File: tb/tb_mac_enc.sv
// Scoreboard bench for mac_enc: directed frames, expected bytes queued at issue, checked by a monitor.
`timescale 1ns/1ps
module tb_mac_enc;
  import mac_enc_pkg::*;

  localparam int unsigned HW = 128;
`ifdef MAC_ENC_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [HW-1:0] h_fifo_dout;
  logic          h_fifo_empty;
  logic          h_fifo_rden;
  logic [7:0]    b_fifo_dout;
  logic          b_fifo_empty;
  logic          b_fifo_del;
  logic          b_fifo_rden;
  logic [7:0]    o_fifo_din;
  logic [3:0]    o_fifo_wren;
  logic          o_fifo_del;
  logic [3:0]    o_fifo_afull = 4'h0;

  typedef struct packed { logic [7:0] d; logic [3:0] wren; logic del; } exp_t;
  typedef struct packed { logic [7:0] d; logic del; } body_t;

  exp_t          exp_q[$];
  int            flen_q[$];
  logic [HW-1:0] hq[$];
  body_t         bq[$];

  int          vectors = 0;
  int          fails = 0;
  int          mon_fbytes = 0;
  logic [31:0] mon_crc = 32'hFFFF_FFFF;
  int          bpops = 0;
  bit          toggle_en = 1'b0;
  bit          gate = 1'b0;

  mac_enc #(.HEADER_DWIDTH(HW)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .h_fifo_dout  (h_fifo_dout),
    .h_fifo_empty (h_fifo_empty),
    .h_fifo_rden  (h_fifo_rden),
    .b_fifo_dout  (b_fifo_dout),
    .b_fifo_empty (b_fifo_empty),
    .b_fifo_del   (b_fifo_del),
    .b_fifo_rden  (b_fifo_rden),
    .o_fifo_din   (o_fifo_din),
    .o_fifo_wren  (o_fifo_wren),
    .o_fifo_del   (o_fifo_del),
    .o_fifo_afull (o_fifo_afull)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @%0t: actual 0x%0h, required 0x%0h", name, $time, act, req);
    end
  endfunction

  // Non-reflected CRC-32 fed with each byte LSB first (wire order).
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic void drive_fifos();
    h_fifo_empty = (hq.size() == 0);
    h_fifo_dout  = (hq.size() != 0) ? hq[0] : '0;
    b_fifo_empty = (bq.size() == 0) || gate;
    b_fifo_dout  = (bq.size() != 0) ? bq[0].d : 8'h00;
    b_fifo_del   = (bq.size() != 0) ? bq[0].del : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [1:0] port, input bit fcs_ok, input int len,
                            input logic [7:0] start, input int exp_len);
    logic [47:0]   dst;
    logic [47:0]   src;
    logic [15:0]   typ;
    logic [HW-1:0] hw;
    logic [7:0]    fr[$];
    logic [31:0]   c;
    logic [31:0]   fcs;
    logic [3:0]    wr;
    dst = 48'hDA02_0304_0506;
    src = 48'h5A0A_0B0C_0D0E;
    typ = 16'h0800;
    hw = '0;
    hw[DST_LSB +: 48]  = dst;
    hw[SRC_LSB +: 48]  = src;
    hw[TYPE_LSB +: 16] = typ;
    hw[PORT_LSB +: 2]  = port;
    hw[FCS_OK_BIT]     = fcs_ok;
    hq.push_back(hw);
    for (int i = 0; i < len; i++) bq.push_back(body_t'({8'(start + i), 1'(i == len - 1)}));
    if (fcs_ok) begin
      for (int i = 0; i < 6; i++) fr.push_back(dst[47 - 8*i -: 8]);
      for (int i = 0; i < 6; i++) fr.push_back(src[47 - 8*i -: 8]);
      fr.push_back(typ[15:8]);
      fr.push_back(typ[7:0]);
      for (int i = 0; i < len; i++) fr.push_back(8'(start + i));
      if (PAD) while (fr.size() < MIN_FRAME_LEN) fr.push_back(8'h00);
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < fr.size(); i++) c = crc_step(c, fr[i]);
      fcs = ~bitrev32(c);
      for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
      wr = 4'(4'd1 << port);
      for (int i = 0; i < fr.size(); i++) exp_q.push_back(exp_t'({fr[i], wr, 1'(i == fr.size() - 1)}));
      flen_q.push_back(exp_len);
    end
    drive_fifos();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || (hq.size() != 0) || (bq.size() != 0)) && (n < 4*MAX_FRAME_LEN)) begin
      tick();
      n++;
    end
    repeat (3) tick();
    if (n >= 4*MAX_FRAME_LEN) begin
      vectors++;
      fails++;
      $display("FAIL %s_timeout: %0d bytes still expected, required 0", name, exp_q.size());
    end
  endtask

  // FIFO models: pops use the rden seen at the edge, then new heads are presented.
  initial begin
    logic ph, pb, eh, eb;
    forever begin
      @(posedge clk);
      ph = h_fifo_rden;
      pb = b_fifo_rden;
      eh = h_fifo_empty;
      eb = b_fifo_empty;
      #1;
      if (ph) begin
        chk("h_pop_when_empty", 32'(eh), 32'h0);
        if (!eh) void'(hq.pop_front());
      end
      if (pb) begin
        chk("b_pop_when_empty", 32'(eb), 32'h0);
        if (!eb) begin
          void'(bq.pop_front());
          bpops++;
        end
      end
      gate = toggle_en ? ~gate : 1'b0;
      drive_fifos();
    end
  end

  // Monitor: every write must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (arst_n && (o_fifo_wren != 4'h0)) begin
        if (exp_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_write @%0t: din=0x%0h wren=%b del=%b, required no write",
                   $time, o_fifo_din, o_fifo_wren, o_fifo_del);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte{din,wren,del}", 32'({o_fifo_din, o_fifo_wren, o_fifo_del}), 32'(e));
        end
        mon_crc = crc_step(mon_crc, o_fifo_din);
        mon_fbytes++;
        if (o_fifo_del) begin
          chk("fcs_residue", mon_crc, CRC_RESIDUE);
          if (flen_q.size() != 0) chk("frame_len", 32'(mon_fbytes), 32'(flen_q.pop_front()));
          mon_crc    = 32'hFFFF_FFFF;
          mon_fbytes = 0;
        end
      end else if (arst_n && o_fifo_del) begin
        vectors++;
        fails++;
        $display("FAIL del_without_write @%0t: del=1 wren=0, required del=0", $time);
      end
    end
  end

  initial begin
    int hp;
    int n;
    drive_fifos();
    repeat (3) tick();
    chk("rst_h_fifo_rden", 32'(h_fifo_rden), 32'h0);
    chk("rst_b_fifo_rden", 32'(b_fifo_rden), 32'h0);
    chk("rst_o_fifo_din", 32'(o_fifo_din), 32'h0);
    chk("rst_o_fifo_wren", 32'(o_fifo_wren), 32'h0);
    chk("rst_o_fifo_del", 32'(o_fifo_del), 32'h0);
    arst_n = 1'b1;
    tick();

    // 46-byte body to port 2: exactly 64 bytes without padding
    send_frame(2'd2, 1'b1, 46, 8'h00, 64);
    wait_done("port2_64b");

    // 10-byte body: padded to 64 or left at 28
    send_frame(2'd0, 1'b1, 10, 8'h40, PAD ? 64 : 28);
    wait_done("short_frame");

    // Bad-FCS header: body drained, nothing written, then a normal frame
    bpops = 0;
    send_frame(2'd3, 1'b0, 100, 8'h80, 0);
    wait_done("drop");
    chk("drop_body_pops", 32'(bpops), 32'd100);
    send_frame(2'd3, 1'b1, 20, 8'h10, PAD ? 64 : 38);
    wait_done("after_drop");

    // Target port almost full: header must wait
    o_fifo_afull = 4'b0010;
    bpops = 0;
    hp = 0;
    send_frame(2'd1, 1'b1, 16, 8'hC0, PAD ? 64 : 34);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (h_fifo_rden) hp++;
    end
    chk("afull_no_hpop", 32'(hp), 32'h0);
    chk("afull_no_bpop", 32'(bpops), 32'h0);
    o_fifo_afull = 4'b0000;
    tick();
    chk("hpop_after_afull", 32'(h_fifo_rden), 32'h1);
    tick();
    chk("first_hdr_byte_latency", 32'(o_fifo_wren), 32'h2);
    wait_done("afull");

    // Body empty every other cycle, afull raised mid-frame (ignored)
    toggle_en = 1'b1;
    send_frame(2'd3, 1'b1, 200, 8'h00, 218);
    repeat (40) tick();
    o_fifo_afull = 4'hF;
    repeat (20) tick();
    o_fifo_afull = 4'h0;
    wait_done("stall_toggle");
    toggle_en = 1'b0;

    // Reset at payload byte 30, then a clean frame
    send_frame(2'd0, 1'b1, 60, 8'h20, 78);
    n = 0;
    while ((mon_fbytes < 44) && (n < 1000)) begin
      tick();
      n++;
    end
    chk("reach_payload_byte30", 32'(mon_fbytes >= 44), 32'h1);
    arst_n = 1'b0;
    #1;
    chk("midframe_rst_outputs", 32'({o_fifo_din, o_fifo_wren, o_fifo_del, h_fifo_rden, b_fifo_rden}), 32'h0);
    exp_q.delete();
    flen_q.delete();
    hq.delete();
    bq.delete();
    mon_crc    = 32'hFFFF_FFFF;
    mon_fbytes = 0;
    drive_fifos();
    repeat (2) tick();
    arst_n = 1'b1;
    tick();
    send_frame(2'd1, 1'b1, 5, 8'h33, PAD ? 64 : 23);
    wait_done("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/mac_enc.md
MAC_ENC -- requirements
Module: mac_enc

Interface
REQ-001 Parameter: HEADER_DWIDTH, default 128, width of header FIFO word.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 arst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 h_fifo_dout  in  HEADER_DWIDTH  first-word-fall-through header word. [111:64]=DST_MAC, [63:16]=SRC_MAC, [15:0]=TYPE, [113:112]=egress port, [115]=FCS_OK.
REQ-005 h_fifo_empty  in  1  header FIFO empty.
REQ-006 h_fifo_rden  out  1  header pop.
REQ-007 b_fifo_dout  in  8  FWFT body byte.
REQ-008 b_fifo_empty  in  1  body FIFO empty.
REQ-009 b_fifo_del  in  1  current body byte is last of frame.
REQ-010 b_fifo_rden  out  1  body pop.
REQ-011 o_fifo_din  out  8  TX byte, shared by all four PHY-TX FIFOs.
REQ-012 o_fifo_wren  out  4  one-hot write strobe, bit n = PHY n.
REQ-013 o_fifo_del  out  1  delimiter, qualifies the last byte written.
REQ-014 o_fifo_afull  in  4  PHY n TX FIFO has fewer than 1518 bytes free.

Function
REQ-015 FSM states: IDLE, HEADER, PAYLOAD, PAD, FCS, DROP, END; undefined encodings go to END.
REQ-016 IDLE: header not empty, FCS_OK=1, o_fifo_afull[port]=0 -> latch header, pulse h_fifo_rden 1 cycle, reset CRC, go to HEADER.
REQ-017 IDLE: header not empty, FCS_OK=0 -> pulse h_fifo_rden, go to DROP.
REQ-018 IDLE: target afull -> wait; no pops, no writes.
REQ-019 HEADER: emit 14 bytes, one per cycle, order DST[47:40]..DST[7:0], SRC, TYPE[15:8], TYPE[7:0]; go to PAYLOAD.
REQ-020 PAYLOAD: body not empty -> write b_fifo_dout, pop body; body empty -> stall, no write; byte with b_fifo_del=1 ends payload.
REQ-021 A frame of 0 payload bytes is not possible; a body whose first byte carries b_fifo_del is one byte long.
REQ-022 After payload: byte count (header+payload) < 60 and padding compiled in -> PAD; else FCS.
REQ-023 PAD: write 0x00 until byte count = 60.
REQ-024 FCS: write 4 FCS bytes = complement of bit-reflected CRC-32 (poly 0x04C11DB7, init all-ones) over all preceding bytes, least-significant byte first; o_fifo_del=1 with 4th byte only.
REQ-025 DROP: pop body every cycle it is not empty, no o_fifo writes, exit to END after popping byte with b_fifo_del=1.
REQ-026 END: one cycle, clears counters/latched header, returns to IDLE; min inter-frame gap = 1 idle cycle.
REQ-027 Output timing: o_fifo_din/o_fifo_wren/o_fifo_del registered; first header byte written 1 cycle after h_fifo_rden pulse.
REQ-028 Byte counter 11 bits, saturating at 2047; frames longer than 1514 pre-FCS bytes are passed unmodified; afull guarantee is caller's responsibility.
REQ-029 o_fifo_afull is sampled only in IDLE; mid-frame assertion ignored.
REQ-030 h_fifo_rden and b_fifo_rden never asserted while respective empty=1.

Reset
REQ-031 arst_n low: all outputs 0, state IDLE, CRC register all-ones, counters 0, latched header 0.
REQ-032 Reset mid-frame abandons frame; no delimiter written; partial frame cleanup is the TX FIFO's responsibility.

Configuration
REQ-033 Macro MAC_ENC_PAD_EN defined: short frames padded per REQ-022/023.
REQ-034 Macro absent: PAD state unreachable; FCS follows last payload byte regardless of length.

Structure
REQ-035 Shared package: header bit-field offsets, MIN_FRAME_LEN=60, MAX_FRAME_LEN=1514, CRC residue 32'hC704_DD7B, FSM state encoding.
REQ-036 Sub-module: existing crc (8-bit/cycle CRC-32) instantiated once, enable = any o_fifo write in HEADER/PAYLOAD/PAD.

Verification
REQ-037 Header port=2, 46-byte body 0x00..0x2D -> only o_fifo_wren[2] active, 64 bytes, del on byte 64, receiver CRC residue 0xC704_DD7B.
REQ-038 MAC_ENC_PAD_EN, 10-byte body -> 24 data bytes + 36 0x00 + 4 FCS = 64 bytes; without macro -> 28 bytes.
REQ-039 FCS_OK=0, 100-byte body -> 100 body pops, zero o_fifo writes, next frame sent normally.
REQ-040 o_fifo_afull[1]=1 with port=1 header pending for 50 cycles -> no pops; deassert -> header popped next cycle.
REQ-041 b_fifo_empty toggled every other cycle during 200-byte payload -> output bytes identical, contiguous order, correct FCS.
REQ-042 arst_n low at payload byte 30 -> all outputs 0 next cycle; after release, next header frame correct.
